// File: rtl/reg_file_rw_if.sv
// Register-file access bundle: write port, two operand read ports, debug read port and write counter.
interface reg_file_rw_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              reg_write;
    logic [ADDR_W-1:0] write_reg;
    logic [DATA_W-1:0] write_data;
    logic [ADDR_W-1:0] read_reg1;
    logic [ADDR_W-1:0] read_reg2;
    logic [DATA_W-1:0] read_data1;
    logic [DATA_W-1:0] read_data2;
    logic [ADDR_W-1:0] dbg_reg;
    logic [DATA_W-1:0] dbg_data;
    logic [15:0]       write_count;

    modport master (
        output reg_write, write_reg, write_data, read_reg1, read_reg2, dbg_reg,
        input  read_data1, read_data2, dbg_data, write_count
    );
    modport slave (
        input  reg_write, write_reg, write_data, read_reg1, read_reg2, dbg_reg,
        output read_data1, read_data2, dbg_data, write_count
    );
endinterface

// File: rtl/reg_file_rw.sv
// MIPS general-purpose register file: r0 hardwired to zero, two combinational read ports,
// optional same-cycle write forwarding, registered debug port and committed-write counter.
module reg_file_rw #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter bit BYPASS = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    reg_file_rw_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0][DATA_W-1:0] regs;
    logic                         wr_en;
    logic [DATA_W-1:0]            dbg_nxt;

    // Gating on reg_write first keeps an unknown write_reg from reaching the array.
    assign wr_en = bus.reg_write && (bus.write_reg != '0);

    function automatic logic [DATA_W-1:0] rd_port(
        input logic [ADDR_W-1:0]            a,
        input logic [DEPTH-1:0][DATA_W-1:0] r,
        input logic                         we,
        input logic [ADDR_W-1:0]            wa,
        input logic [DATA_W-1:0]            wd
    );
        if (a == '0)                      return '0;
        else if (BYPASS && we && wa == a) return wd;
        else                              return r[a];
    endfunction

    always_comb begin
        bus.read_data1 = rd_port(bus.read_reg1, regs, bus.reg_write, bus.write_reg, bus.write_data);
        bus.read_data2 = rd_port(bus.read_reg2, regs, bus.reg_write, bus.write_reg, bus.write_data);
        dbg_nxt        = rd_port(bus.dbg_reg,   regs, bus.reg_write, bus.write_reg, bus.write_data);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     regs <= '0;
        else if (wr_en) regs[bus.write_reg] <= bus.write_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.write_count <= '0;
            bus.dbg_data    <= '0;
        end else begin
            if (wr_en) bus.write_count <= bus.write_count + 16'd1;
            bus.dbg_data <= dbg_nxt;
        end
    end
endmodule

// File: doc/reg_file_rw.md
Name: reg_file_rw

Overview:
- 32-entry x 32-bit general-purpose register file for the single-cycle MIPS datapath.
- It is the consuming end of the 5-bit write-destination select path. It takes the selected destination register number, write data and write enable, and commits on the clock edge.
- It serves two combinational operand read ports (rs, rt) plus one debug read port for the board display.
- Register 0 is hardwired to zero.

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, register-number width; depth = 2**ADDR_W
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads return stored value only

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- reg_write  input  1  write enable for current cycle
- write_reg  input  ADDR_W  destination register number (output of destination-select mux)
- write_data  input  DATA_W  data to commit
- read_reg1  input  ADDR_W  rs register number
- read_reg2  input  ADDR_W  rt register number
- read_data1  output  DATA_W  rs operand, combinational
- read_data2  output  DATA_W  rt operand, combinational
- dbg_reg  input  ADDR_W  debug read register number
- dbg_data  output  DATA_W  debug read value, registered (1-cycle latency)
- write_count  output  16  number of committed non-zero-destination writes since reset

Behaviour:
- Reset (rst_n = 0, asynchronous): all 32 entries cleared to 0; dbg_data = 0; write_count = 0. Read ports then return 0 for every address. Reset asserted mid-cycle overrides any write in that cycle.
- Write, on posedge clk with rst_n = 1:
  - if reg_write = 1 and write_reg != 0: entry[write_reg] <= write_data, and write_count increments by 1.
  - write_count wraps 0xFFFF -> 0x0000 with no saturation.
  - writes to register 0 are discarded and do not increment write_count.
- Read ports:
  - read_dataN = 0 when read_regN = 0, regardless of any write.
  - else, when BYPASS = 1 and reg_write = 1 and write_reg = read_regN, read_dataN = write_data (same-cycle forwarding).
  - else read_dataN = entry[read_regN].
  - Both ports are fully independent; the same address on both ports returns the same value.
- Debug port:
  - posedge clk: dbg_data <= value that read port logic would return for dbg_reg, including the bypass rule and the zero rule.
  - 1-cycle latency.
- Simultaneous events:
  - a write and a read of the same register in one cycle return new data when BYPASS = 1, old data when BYPASS = 0.
  - the stored value updates at the edge in both cases.
- There is no handshake. Every cycle with reg_write = 1 is a commit, and there is no backpressure.
- X or unknown write_reg with reg_write = 0 must not corrupt state.

Test Plan:
- Reset: drive rst_n = 0 between edges -> read_data1/2 = 0 for addresses 0..31 immediately; write_count = 0; dbg_data = 0.
- Basic write/read: write 0xDEADBEEF to r8, then read_reg1 = 8 next cycle -> read_data1 = 0xDEADBEEF. Then write 0x12345678 to r31 and read both ports at 8/31 -> both values correct.
- Zero register: reg_write = 1, write_reg = 0, write_data = 0xFFFFFFFF -> read of r0 = 0; write_count unchanged.
- Bypass: in the same cycle write r5 = 0x0000_00A5 and read_reg2 = 5.
  - BYPASS = 1 -> read_data2 = 0x000000A5 before the edge.
  - BYPASS = 0 -> read_data2 = old r5 value before the edge, 0xA5 after.
- Write disable and reset mid-operation:
  - reg_write = 0 with write_reg = 9 -> r9 unchanged.
  - assert rst_n low while reg_write = 1 to r9 -> r9 = 0 and the write is lost.
- Counter wrap and debug latency:
  - preload via 65535 writes to r1, then one more -> write_count = 0.
  - dbg_reg = 1 -> dbg_data shows r1 one cycle later.
